// File: rtl/prio_arbiter_ctrl_pkg.sv
// rtl/prio_arbiter_ctrl_pkg.sv - arbiter state type and grant helper
package prio_arbiter_ctrl_pkg;
  `include "arb_defs.vh"

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_BUSY = ST_BUSY,
    S_GAP  = ST_GAP
  } arb_state_e;

  // Up to 8 requesters; callers keep the low N bits.
  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction
endpackage

// File: rtl/arb_defs.vh
// rtl/arb_defs.vh - shared arbiter FSM state encodings
`ifndef ARB_DEFS_VH
`define ARB_DEFS_VH
localparam logic [1:0] ST_IDLE = 2'd0;
localparam logic [1:0] ST_BUSY = 2'd1;
localparam logic [1:0] ST_GAP  = 2'd2;
`endif

// File: rtl/prio_enc_n.sv
// rtl/prio_enc_n.sv - highest-set-bit priority encoder
module prio_enc_n #(
  parameter int N    = 3,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  output logic            valid,
  output logic [ID_W-1:0] idx
);
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) idx = ID_W'(i);
    end
  end
endmodule

// File: rtl/prio_arbiter_ctrl.sv
// rtl/prio_arbiter_ctrl.sv - transaction-holding priority arbiter
module prio_arbiter_ctrl
  import prio_arbiter_ctrl_pkg::*;
#(
  parameter int N        = 3,
  parameter int ID_W     = 2,
  parameter int RR       = 0,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            busy,
  output logic            timeout
);
  localparam int HC_W = $clog2(MAX_HOLD) + 1;
  localparam logic [HC_W-1:0] HC_MAX     = '1;
  localparam logic [HC_W-1:0] HOLD_LIMIT = HC_W'(MAX_HOLD - 1);

  arb_state_e      state;
  logic [HC_W-1:0] hold_cnt;
  logic [ID_W-1:0] last_id;

  logic [N-1:0]    rr_mask;
  logic [N-1:0]    masked_req;
  logic            raw_valid;
  logic            msk_valid;
  logic [ID_W-1:0] raw_idx;
  logic [ID_W-1:0] msk_idx;
  logic [ID_W-1:0] win_id;
  logic [7:0]      win_onehot;
  logic            owner_req;

  // Round-robin looks only below the previous owner first, so rotation runs downward.
  assign rr_mask    = ~({N{1'b1}} << last_id);
  assign masked_req = req & rr_mask;

  prio_enc_n #(.N(N), .ID_W(ID_W)) u_enc_raw (
    .req   (req),
    .valid (raw_valid),
    .idx   (raw_idx)
  );

  prio_enc_n #(.N(N), .ID_W(ID_W)) u_enc_msk (
    .req   (masked_req),
    .valid (msk_valid),
    .idx   (msk_idx)
  );

  assign win_id     = (RR != 0 && msk_valid) ? msk_idx : raw_idx;
  assign win_onehot = onehot8(3'(win_id));
  assign owner_req  = |(req & gnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      last_id  <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (raw_valid) begin
            gnt      <= win_onehot[N-1:0];
            gnt_id   <= win_id;
            busy     <= 1'b1;
            hold_cnt <= '0;
            state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (!owner_req) begin
            gnt     <= '0;
            busy    <= 1'b0;
            last_id <= gnt_id;
            state   <= S_GAP;
          end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LIMIT) begin
            gnt     <= '0;
            busy    <= 1'b0;
            timeout <= 1'b1;
            last_id <= gnt_id;
            state   <= S_GAP;
          end else if (hold_cnt != HC_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_GAP:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prio_arbiter_ctrl.sv
// tb/tb_prio_arbiter_ctrl.sv - scoreboard bench for fixed-priority and round-robin arbiters
module tb_prio_arbiter_ctrl;
  localparam int N      = 3;
  localparam int ID_W   = 2;
  localparam int NRAND  = 2000;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    req0, req1;
  logic [N-1:0]    gnt0, gnt1;
  logic [ID_W-1:0] gnt_id0, gnt_id1;
  logic            busy0, busy1, timeout0, timeout1;

  always #5 clk = ~clk;

  prio_arbiter_ctrl #(.N(N), .ID_W(ID_W), .RR(0), .MAX_HOLD(4)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .gnt(gnt0), .gnt_id(gnt_id0),
    .busy(busy0), .timeout(timeout0)
  );

  prio_arbiter_ctrl #(.N(N), .ID_W(ID_W), .RR(1), .MAX_HOLD(0)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .gnt(gnt1), .gnt_id(gnt_id1),
    .busy(busy1), .timeout(timeout1)
  );

  typedef struct {
    logic [N-1:0] gnt;
    int           id;
    logic         busy;
    logic         timeout;
    int           cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int compared = 0;
  int mismatched = 0;

  // Reference model: phase 0 idle, 1 owned, 2 turnaround.
  int m_rr[2]  = '{0, 1};
  int m_max[2] = '{4, 0};
  int m_phase[2], m_owner[2], m_held[2], m_last[2];
  bit m_to[2];
  int target[2][N];

  function automatic int highest(input int v);
    int r = -1;
    for (int i = 0; i < N; i++) if (((v >> i) & 1) != 0) r = i;
    return r;
  endfunction

  function automatic int pick(input int k, input int r);
    int m;
    if (m_rr[k] != 0) begin
      m = r & ((1 << m_last[k]) - 1);
      if (m != 0) return highest(m);
    end
    return highest(r);
  endfunction

  task automatic model_step(input int k, input bit r, input int rq, input int cyc);
    exp_t e;
    if (r) begin
      m_phase[k] = 0; m_owner[k] = 0; m_held[k] = 0; m_last[k] = 0; m_to[k] = 0;
    end else begin
      m_to[k] = 0;
      if (m_phase[k] == 0) begin
        if (rq != 0) begin
          m_owner[k] = pick(k, rq); m_held[k] = 0; m_phase[k] = 1;
        end
      end else if (m_phase[k] == 1) begin
        if (((rq >> m_owner[k]) & 1) == 0) begin
          m_phase[k] = 2; m_last[k] = m_owner[k];
        end else if (m_max[k] != 0 && m_held[k] == m_max[k] - 1) begin
          m_phase[k] = 2; m_last[k] = m_owner[k]; m_to[k] = 1;
        end else if (m_held[k] < 1000) begin
          m_held[k]++;
        end
      end else begin
        m_phase[k] = 0;
      end
    end
    e.busy    = (m_phase[k] == 1);
    e.gnt     = e.busy ? N'(1 << m_owner[k]) : '0;
    e.id      = m_owner[k];
    e.timeout = m_to[k];
    e.cyc     = cyc;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic check(input int k, input exp_t e, input logic [N-1:0] g,
                       input logic [ID_W-1:0] id, input logic b, input logic t);
    bit ok;
    ok = (g === e.gnt) && (b === e.busy) && (t === e.timeout) &&
         (!e.busy || int'(id) == e.id);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL dut%0d cyc %0d: got gnt=%b id=%0d busy=%b timeout=%b, expected gnt=%b id=%0d busy=%b timeout=%b",
               k, e.cyc, g, id, b, t, e.gnt, e.id, e.busy, e.timeout);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check(0, e, gnt0, gnt_id0, busy0, timeout0);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check(1, e, gnt1, gnt_id1, busy1, timeout1);
    end
  end

  typedef struct { bit r; logic [N-1:0] v; int n; } step_t;
  step_t dir[$] = '{
    '{1'b1, 3'b111, 2}, '{1'b0, 3'b011, 3}, '{1'b0, 3'b001, 4},
    '{1'b0, 3'b101, 4}, '{1'b0, 3'b100, 8}, '{1'b0, 3'b000, 2},
    '{1'b0, 3'b111, 6}, '{1'b1, 3'b111, 1}, '{1'b0, 3'b111, 3}
  };

  initial begin
    bit              cur_rst;
    logic [N-1:0]    cur_req[2];
    int              cyc = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) target[k][i] = 2;
    rst = dir[0].r; req0 = dir[0].v; req1 = dir[0].v;
    cur_rst = dir[0].r; cur_req[0] = dir[0].v; cur_req[1] = dir[0].v;

    // Directed prologue; each entry's inputs are applied for n edges.
    for (int s = 0; s < dir.size(); s++) begin
      for (int j = 0; j < dir[s].n; j++) begin
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, cur_rst, int'(cur_req[k]), cyc);
        cyc++;
        #1;
        if (j == dir[s].n - 1 && s + 1 < dir.size()) begin
          cur_rst = dir[s+1].r; cur_req[0] = dir[s+1].v; cur_req[1] = dir[s+1].v;
        end
        rst = cur_rst; req0 = cur_req[0]; req1 = cur_req[1];
      end
    end

    // Random engines: hold request until served for target cycles, then drop.
    for (int c = 0; c < NRAND; c++) begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_step(k, cur_rst, int'(cur_req[k]), cyc);
      cyc++;
      #1;
      cur_rst = ($urandom_range(59) == 0);
      for (int k = 0; k < 2; k++) begin
        if (m_to[k]) target[k][m_last[k]] = $urandom_range(1, 3);
        for (int i = 0; i < N; i++) begin
          if (m_phase[k] == 1 && m_owner[k] == i) begin
            if (m_held[k] + 1 >= target[k][i]) cur_req[k][i] = 1'b0;
          end else if (!cur_req[k][i]) begin
            if ($urandom_range(2) == 0) begin
              cur_req[k][i] = 1'b1;
              target[k][i]  = $urandom_range(1, 6);
            end
          end
        end
      end
      rst = cur_rst; req0 = cur_req[0]; req1 = cur_req[1];
    end

    repeat (3) @(negedge clk);
    #1;
    compared++;
    if (q0.size() + q1.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expected entries left, required 0", q0.size() + q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
